axi_mem_arbiter: RTL and testbench
==================================

AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the byte-address width of all address ports.
REQ-002 Parameter BL_LOG2, default 3, SHALL set the memory burst as 2**BL_LOG2 beats; command addresses SHALL have their low BL_LOG2 bits zero.
REQ-003 S_AXI_ACLK  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 RD_REQ_VALID  in  1  read request (decoded AR) pending.
REQ-006 RD_REQ_READY  out  1  read request accepted this cycle.
REQ-007 RD_REQ_ADDR  in  ADDR_WIDTH  read start address.
REQ-008 RD_REQ_LEN  in  8  read beats minus 1 (AxLEN encoding).
REQ-009 WR_REQ_VALID / WR_REQ_READY / WR_REQ_ADDR / WR_REQ_LEN  in/out/in/in  1/1/ADDR_WIDTH/8  write-side equivalents of REQ-005..008.
REQ-010 MEM_CMD_VALID  out  1  memory command valid.
REQ-011 MEM_CMD_READY  in  1  memory accepts command.
REQ-012 MEM_CMD_ADDR  out  ADDR_WIDTH  burst-aligned command address.
REQ-013 MEM_CMD_WE  out  1  1 = write command, 0 = read command.
REQ-014 RD_DONE / WR_DONE  out  1 each  one-cycle pulse when all commands of a request are issued.
REQ-015 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DONE.
REQ-017 In IDLE, the arbiter SHALL grant one side per cycle; a request is accepted when its REQ_VALID and REQ_READY are both high.
REQ-018 REQ_READY SHALL be combinational: high only in IDLE, only for the granted side, and only while that side's REQ_VALID is high.
REQ-019 Arbitration SHALL be round-robin: a lone requester is granted; on simultaneous requests, the side not served last is granted.
REQ-020 On acceptance, the block SHALL register the request's address, length and direction, and SHALL enter ISSUE.
REQ-021 Command count SHALL be ((ADDR[BL_LOG2-1:0] + LEN) >> BL_LOG2) + 1, computed at least 9 bits wide; for defaults this gives 1..33.
REQ-022 The first command SHALL appear the cycle after acceptance, with MEM_CMD_ADDR = ADDR with the low BL_LOG2 bits cleared.
REQ-023 Each subsequent command address SHALL be the previous one + 2**BL_LOG2, wrapping modulo 2**ADDR_WIDTH.
REQ-024 While MEM_CMD_VALID is high and MEM_CMD_READY is low, MEM_CMD_ADDR and MEM_CMD_WE SHALL hold stable.
REQ-025 MEM_CMD_VALID SHALL stay high through back-to-back accepted commands, giving one command per cycle when MEM_CMD_READY stays high.
REQ-026 On acceptance of the last command, the FSM SHALL enter DONE and MEM_CMD_VALID SHALL go low on the next edge.
REQ-027 DONE SHALL last exactly one cycle, pulse RD_DONE or WR_DONE, hold both REQ_READYs low, update last-served, and return to IDLE.
REQ-028 Requests arriving outside IDLE SHALL wait and SHALL not be dropped; the inactive side's REQ_READY SHALL remain low.

Reset
REQ-029 Asserting S_AXI_ARESETN low SHALL immediately force state IDLE.
REQ-030 The same reset SHALL force MEM_CMD_VALID, MEM_CMD_WE, MEM_CMD_ADDR, RD_DONE, WR_DONE and BUSY to 0, and clear all counters.
REQ-031 Reset SHALL set last-served to write, so the first contended grant goes to read.
REQ-032 Reset mid-ISSUE SHALL abandon the remaining commands without completion pulses; operation SHALL resume on the first edge after release.

Configuration
REQ-033 When macro AXI_MEM_ARBITER_RD_PRIORITY_EN is defined, a simultaneous request SHALL always grant read, and last-served SHALL be ignored.
REQ-034 When AXI_MEM_ARBITER_RD_PRIORITY_EN is undefined, round-robin per REQ-019 SHALL apply.

Verification
REQ-035 Read ADDR=0x10, LEN=7, MEM_CMD_READY=1 -> one read command at 0x10, then RD_DONE one cycle later, BUSY high for 2 cycles.
REQ-036 Read ADDR=0x05, LEN=7 -> two read commands at 0x00 and 0x08.
REQ-037 Read ADDR=0xF8, LEN=15 -> read commands at 0xF8 and 0x00, showing address wrap.
REQ-038 RD_REQ_VALID and WR_REQ_VALID both held high after reset, LEN=0 each -> grant order R, W, R, W (read always under _RD_PRIORITY_EN).
REQ-039 Write ADDR=0x20, LEN=23, MEM_CMD_READY low for 3 cycles on the 2nd command -> commands at 0x20, 0x28 (held stable 4 cycles), 0x30; WR_DONE one pulse.
REQ-040 Reset asserted during the 2nd of 3 commands -> MEM_CMD_VALID low immediately, no DONE pulse; a fresh request after release is served normally.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: arbitrates decoded AXI read/write requests into a stream of
// burst-aligned memory commands (one command per 2**BL_LOG2-beat burst).
// Optional build macro: AXI_MEM_ARBITER_RD_PRIORITY_EN -- when defined, reads
// always win simultaneous requests; otherwise arbitration is round-robin.
module axi_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int BL_LOG2    = 3
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  RD_REQ_VALID,
  output logic                  RD_REQ_READY,
  input  logic [ADDR_WIDTH-1:0] RD_REQ_ADDR,
  input  logic [7:0]            RD_REQ_LEN,
  input  logic                  WR_REQ_VALID,
  output logic                  WR_REQ_READY,
  input  logic [ADDR_WIDTH-1:0] WR_REQ_ADDR,
  input  logic [7:0]            WR_REQ_LEN,
  output logic                  MEM_CMD_VALID,
  input  logic                  MEM_CMD_READY,
  output logic [ADDR_WIDTH-1:0] MEM_CMD_ADDR,
  output logic                  MEM_CMD_WE,
  output logic                  RD_DONE,
  output logic                  WR_DONE,
  output logic                  BUSY
);

  // 9 bits covers the worst case of (2**BL_LOG2-1 + 255) >> BL_LOG2, plus one.
  localparam int CNT_W = 9;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(1 << BL_LOG2);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'((1 << BL_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    last_wr_q, last_wr_d;

  logic                    idle;
  logic                    grant_rd;
  logic                    grant_wr;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [7:0]              sel_len;
  logic [CNT_W-1:0]        cmd_total;

  assign idle = (state_q == ST_IDLE);

`ifdef AXI_MEM_ARBITER_RD_PRIORITY_EN
  // Reads win any tie; last-served history plays no part in the grant.
  assign grant_rd = RD_REQ_VALID;
`else
  // Read wins when alone, or on a tie when write was the side served last.
  assign grant_rd = RD_REQ_VALID & (~WR_REQ_VALID | last_wr_q);
`endif
  assign grant_wr = WR_REQ_VALID & ~grant_rd;

  assign RD_REQ_READY = idle & grant_rd;
  assign WR_REQ_READY = idle & grant_wr;
  assign accept       = RD_REQ_READY | WR_REQ_READY;

  assign sel_addr  = grant_rd ? RD_REQ_ADDR : WR_REQ_ADDR;
  assign sel_len   = grant_rd ? RD_REQ_LEN  : WR_REQ_LEN;
  // Bursts touched = (beat offset inside first burst + extra beats) / burst + 1.
  assign cmd_total = ((CNT_W'(sel_addr[BL_LOG2-1:0]) + CNT_W'(sel_len)) >> BL_LOG2)
                     + CNT_W'(1);

  // Next-state logic: capture a granted request, then walk its burst addresses.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = sel_addr & ALIGN_MASK;
          cnt_d   = cmd_total;
          we_d    = ~grant_rd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (MEM_CMD_READY) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + BURST_BYTES;
          end
        end
      end
      ST_DONE: begin
        last_wr_d = we_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset abandons any in-flight request.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign MEM_CMD_VALID = (state_q == ST_ISSUE);
  assign MEM_CMD_ADDR  = addr_q;
  assign MEM_CMD_WE    = we_q;
  assign RD_DONE       = (state_q == ST_DONE) & ~we_q;
  assign WR_DONE       = (state_q == ST_DONE) &  we_q;
  assign BUSY          = ~idle;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_axi_mem_arbiter;

  logic       S_AXI_ACLK = 1'b0;
  logic       S_AXI_ARESETN;
  logic       RD_REQ_VALID, RD_REQ_READY;
  logic [7:0] RD_REQ_ADDR, RD_REQ_LEN;
  logic       WR_REQ_VALID, WR_REQ_READY;
  logic [7:0] WR_REQ_ADDR, WR_REQ_LEN;
  logic       MEM_CMD_VALID, MEM_CMD_READY, MEM_CMD_WE;
  logic [7:0] MEM_CMD_ADDR;
  logic       RD_DONE, WR_DONE, BUSY;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  axi_mem_arbiter #(.ADDR_WIDTH(8), .BL_LOG2(3)) dut (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .RD_REQ_VALID (RD_REQ_VALID),
    .RD_REQ_READY (RD_REQ_READY),
    .RD_REQ_ADDR  (RD_REQ_ADDR),
    .RD_REQ_LEN   (RD_REQ_LEN),
    .WR_REQ_VALID (WR_REQ_VALID),
    .WR_REQ_READY (WR_REQ_READY),
    .WR_REQ_ADDR  (WR_REQ_ADDR),
    .WR_REQ_LEN   (WR_REQ_LEN),
    .MEM_CMD_VALID(MEM_CMD_VALID),
    .MEM_CMD_READY(MEM_CMD_READY),
    .MEM_CMD_ADDR (MEM_CMD_ADDR),
    .MEM_CMD_WE   (MEM_CMD_WE),
    .RD_DONE      (RD_DONE),
    .WR_DONE      (WR_DONE),
    .BUSY         (BUSY)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus state: pending requests per side and how many repeats each keeps.
  bit         rd_pend, wr_pend;
  logic [7:0] rd_a, rd_l, wr_a, wr_l;
  int         rd_rep, wr_rep;
  int         stall_mode;   // 0 always ready, 1 random, 2 stall 3 cycles on 2nd cmd
  int         stall_left;

  // Reference model: outstanding command addresses of the active request.
  logic [7:0] cmdq[$];
  bit         cur_we;
  bit         done_due;
  bit         last_wr;
  int         cmd_idx;

  // Observations taken from the DUT.
  logic [7:0] obs_cmds[$];
  bit         grant_log[$];
  int         busy_cycles, rd_done_cnt, wr_done_cnt, cyc28;

  function automatic void load(input bit we, input logic [7:0] a, input logic [7:0] l);
    int off  = int'(a) % 8;
    int n    = (off + int'(l)) / 8 + 1;
    int base = int'(a) - off;
    cmdq.delete();
    for (int k = 0; k < n; k++) cmdq.push_back(8'((base + 8 * k) % 256));
    cur_we  = we;
    cmd_idx = 0;
  endfunction

  function automatic void model_reset();
    cmdq.delete();
    done_due = 0;
    last_wr  = 1;
    rd_pend  = 0;
    wr_pend  = 0;
    rd_rep   = 0;
    wr_rep   = 0;
  endfunction

  function automatic void clear_obs();
    obs_cmds.delete();
    grant_log.delete();
    busy_cycles = 0;
    rd_done_cnt = 0;
    wr_done_cnt = 0;
    cyc28       = 0;
  endfunction

  task automatic drive_idle();
    RD_REQ_VALID  = 0; RD_REQ_ADDR = 0; RD_REQ_LEN = 0;
    WR_REQ_VALID  = 0; WR_REQ_ADDR = 0; WR_REQ_LEN = 0;
    MEM_CMD_READY = 0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance model.
  task automatic step();
    bit mrdy, exp_idle, g_rd, g_wr;
    @(negedge S_AXI_ACLK);
    case (stall_mode)
      0: mrdy = 1;
      1: mrdy = 1'($urandom_range(0, 1));
      default: begin
        mrdy = 1;
        if (cmdq.size() > 0 && cmd_idx == 1 && stall_left > 0) begin
          mrdy = 0;
          stall_left--;
        end
      end
    endcase
    RD_REQ_VALID = rd_pend; RD_REQ_ADDR = rd_a; RD_REQ_LEN = rd_l;
    WR_REQ_VALID = wr_pend; WR_REQ_ADDR = wr_a; WR_REQ_LEN = wr_l;
    MEM_CMD_READY = mrdy;
    #1;
    exp_idle = (cmdq.size() == 0) && !done_due;
    g_rd = 0;
    g_wr = 0;
    if (exp_idle) begin
      if (rd_pend && wr_pend) begin
`ifdef AXI_MEM_ARBITER_RD_PRIORITY_EN
        g_rd = 1;
`else
        g_rd = last_wr;   // serve the side that did not go last
`endif
        g_wr = !g_rd;
      end else begin
        g_rd = rd_pend;
        g_wr = wr_pend;
      end
    end
    check("rd_ready", RD_REQ_READY, g_rd);
    check("wr_ready", WR_REQ_READY, g_wr);
    check("busy", BUSY, !exp_idle);
    check("cmd_valid", MEM_CMD_VALID, cmdq.size() > 0);
    if (cmdq.size() > 0) begin
      check("cmd_addr", MEM_CMD_ADDR, cmdq[0]);
      check("cmd_we", MEM_CMD_WE, cur_we);
    end
    check("rd_done", RD_DONE, done_due && !cur_we);
    check("wr_done", WR_DONE, done_due && cur_we);

    if (RD_REQ_READY) grant_log.push_back(1'b0);
    if (WR_REQ_READY) grant_log.push_back(1'b1);
    if (MEM_CMD_VALID && mrdy) obs_cmds.push_back(MEM_CMD_ADDR);
    if (MEM_CMD_VALID && MEM_CMD_ADDR == 8'h28) cyc28++;
    if (BUSY) busy_cycles++;
    if (RD_DONE) rd_done_cnt++;
    if (WR_DONE) wr_done_cnt++;

    if (done_due) begin
      done_due = 0;
      last_wr  = cur_we;
    end else if (cmdq.size() > 0) begin
      if (mrdy) begin
        void'(cmdq.pop_front());
        cmd_idx++;
        if (cmdq.size() == 0) done_due = 1;
      end
    end else if (g_rd) begin
      load(1'b0, rd_a, rd_l);
      if (rd_rep > 0) rd_rep--; else rd_pend = 0;
    end else if (g_wr) begin
      load(1'b1, wr_a, wr_l);
      if (wr_rep > 0) wr_rep--; else wr_pend = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_pend || wr_pend || cmdq.size() > 0 || done_due) && n < 1000) begin
      step();
      n++;
    end
    check("drain_timeout", n < 1000, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] packed_g;
    S_AXI_ARESETN = 0;
    drive_idle();
    model_reset();
    clear_obs();
    stall_mode = 0;
    stall_left = 0;
    rd_a = 0; rd_l = 0; wr_a = 0; wr_l = 0;
    #1;
    check("rst_cmd_valid", MEM_CMD_VALID, 1'b0);
    check("rst_cmd_we", MEM_CMD_WE, 1'b0);
    check("rst_cmd_addr", MEM_CMD_ADDR, 8'h00);
    check("rst_rd_done", RD_DONE, 1'b0);
    check("rst_wr_done", WR_DONE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_rd_ready", RD_REQ_READY, 1'b0);
    check("rst_wr_ready", WR_REQ_READY, 1'b0);
    repeat (2) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1;

    // Contended requests straight after reset, two of each, LEN=0.
    clear_obs();
    rd_pend = 1; rd_a = 8'h30; rd_l = 0; rd_rep = 1;
    wr_pend = 1; wr_a = 8'h50; wr_l = 0; wr_rep = 1;
    drain();
    check("contend_grants", grant_log.size(), 4);
    packed_g = 0;
    foreach (grant_log[i]) if (i < 32) packed_g[i] = grant_log[i];
`ifdef AXI_MEM_ARBITER_RD_PRIORITY_EN
    check("contend_order", packed_g, 32'hC);   // R R W W
`else
    check("contend_order", packed_g, 32'hA);   // R W R W
`endif

    // Single aligned read.
    clear_obs();
    rd_pend = 1; rd_a = 8'h10; rd_l = 7;
    drain();
    check("r10_ncmd", obs_cmds.size(), 1);
    if (obs_cmds.size() >= 1) check("r10_addr", obs_cmds[0], 8'h10);
    check("r10_busy", busy_cycles, 2);
    check("r10_done", rd_done_cnt, 1);

    // Unaligned read spans two bursts.
    clear_obs();
    rd_pend = 1; rd_a = 8'h05; rd_l = 7;
    drain();
    check("r05_ncmd", obs_cmds.size(), 2);
    if (obs_cmds.size() >= 2) begin
      check("r05_a0", obs_cmds[0], 8'h00);
      check("r05_a1", obs_cmds[1], 8'h08);
    end

    // Address wrap at the top of the space.
    clear_obs();
    rd_pend = 1; rd_a = 8'hF8; rd_l = 15;
    drain();
    check("rf8_ncmd", obs_cmds.size(), 2);
    if (obs_cmds.size() >= 2) begin
      check("rf8_a0", obs_cmds[0], 8'hF8);
      check("rf8_a1", obs_cmds[1], 8'h00);
    end

    // Write with backpressure on the second command.
    clear_obs();
    stall_mode = 2; stall_left = 3;
    wr_pend = 1; wr_a = 8'h20; wr_l = 23;
    drain();
    check("w20_ncmd", obs_cmds.size(), 3);
    if (obs_cmds.size() >= 3) begin
      check("w20_a0", obs_cmds[0], 8'h20);
      check("w20_a1", obs_cmds[1], 8'h28);
      check("w20_a2", obs_cmds[2], 8'h30);
    end
    check("w20_hold", cyc28, 4);
    check("w20_done", wr_done_cnt, 1);
    stall_mode = 0;

    // Reset in the middle of a three-command write.
    clear_obs();
    wr_pend = 1; wr_a = 8'h40; wr_l = 23;
    step();
    step();
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 0;
    #1;
    check("midrst_valid", MEM_CMD_VALID, 1'b0);
    check("midrst_busy", BUSY, 1'b0);
    drive_idle();
    model_reset();
    repeat (2) begin
      @(negedge S_AXI_ACLK);
      #1;
      check("midrst_rd_done", RD_DONE, 1'b0);
      check("midrst_wr_done", WR_DONE, 1'b0);
    end
    S_AXI_ARESETN = 1;
    rd_pend = 1; rd_a = 8'h10; rd_l = 7;
    drain();
    check("postrst_ncmd", obs_cmds.size(), 2);   // cmd at 0x40 before reset, then 0x10
    if (obs_cmds.size() >= 2) check("postrst_addr", obs_cmds[1], 8'h10);
    check("postrst_rd_done", rd_done_cnt, 1);
    check("postrst_wr_done", wr_done_cnt, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      rd_pend = 1'($urandom_range(0, 1));
      wr_pend = 1'($urandom_range(0, 1));
      if (!rd_pend && !wr_pend) rd_pend = 1;
      rd_a = 8'($urandom_range(0, 255));
      wr_a = 8'($urandom_range(0, 255));
      rd_l = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 40));
      wr_l = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 40));
      rd_rep = rd_pend ? int'($urandom_range(0, 1)) : 0;
      wr_rep = wr_pend ? int'($urandom_range(0, 1)) : 0;
      stall_mode = int'($urandom_range(0, 1));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
